// File: rtl/asi_arb_ctrl.sv
// Two-way burst arbiter for the user memory port: write and read sides compete,
// with a fixed priority side and an optional fairness limit on consecutive grants.
//
// state | meaning
// IDLE  | no grant, arbitrate every cycle
// WGNT  | write side owns the port until its last beat
// RGNT  | read side owns the port until its last beat
module asi_arb_ctrl #(
    parameter int ASI_ARB  = 0,
    parameter int ARB_MAXC = 4,
    parameter int ARB_CW   = $clog2(ARB_MAXC + 1)
) (
    input  logic usr_clk,
    input  logic usr_reset_n,
    input  logic usr_wrequest,
    input  logic usr_we,
    input  logic usr_wlast,
    input  logic usr_rrequest,
    input  logic usr_re,
    input  logic usr_rlast,
    output logic usr_wgrant,
    output logic usr_rgrant,
    output logic arb_busy,
    output logic arb_starve
);

    // ARB_MAXC=0 yields a zero-width counter; keep at least one bit.
    localparam int            CW       = (ARB_CW < 1) ? 1 : ARB_CW;
    localparam logic [CW-1:0] MAXC     = CW'(ARB_MAXC);
    localparam logic          LIMIT_EN = (ARB_MAXC != 0);
    localparam logic          RD_PRI   = (ASI_ARB != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WGNT = 2'd1,
        RGNT = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] fcnt, fcnt_nxt;
    logic          starve, starve_nxt;
    logic          decide, pri_req, oth_req, forced, issue, pick_pri, pick_w;

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            state  <= IDLE;
            fcnt   <= '0;
            starve <= 1'b0;
        end else begin
            state  <= state_nxt;
            fcnt   <= fcnt_nxt;
            starve <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        fcnt_nxt   = fcnt;
        starve_nxt = starve;
        pri_req    = RD_PRI ? usr_rrequest : usr_wrequest;
        oth_req    = RD_PRI ? usr_wrequest : usr_rrequest;

        case (state)
            WGNT:    decide = usr_we && usr_wlast;
            RGNT:    decide = usr_re && usr_rlast;
            default: decide = 1'b1;
        endcase

        forced   = LIMIT_EN && pri_req && oth_req && (fcnt == MAXC);
        issue    = decide && (pri_req || oth_req);
        pick_pri = pri_req && !forced;
        pick_w   = RD_PRI ? !pick_pri : pick_pri;

        if (decide && !issue) begin
            state_nxt = IDLE;
        end else if (issue) begin
            state_nxt  = pick_w ? WGNT : RGNT;
            starve_nxt = forced;
            // Only a priority win against a waiting other side counts toward the limit.
            if (pick_pri && oth_req) begin
                if (fcnt != MAXC) fcnt_nxt = fcnt + CW'(1);
            end else begin
                fcnt_nxt = '0;
            end
        end
    end

    assign usr_wgrant = (state == WGNT);
    assign usr_rgrant = (state == RGNT);
    assign arb_busy   = usr_wgrant | usr_rgrant;
    assign arb_starve = starve;

endmodule
